// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer: state encoding
// (also used by the debug/CSR decode) and parameter defaults.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } pll_state_e;

  localparam int RST_CYCLES_DEF   = 16;
  localparam int LOCK_TIMEOUT_DEF = 50000;
  localparam int LOCK_STABLE_DEF  = 1024;
  localparam int MAX_RETRY_DEF    = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchronizer, async active-low reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer in the refclk domain. Optional loss-of-lock event
// counter is built only when PLL_SEQ_LOL_COUNT_EN is defined.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES   = RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [2:0] state_o,
  output logic [7:0] lol_count
);

  localparam int CW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE)) + 1;
  localparam int RW = $clog2(MAX_RETRY) + 1;

  pll_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [RW-1:0] retry, retry_nx;
  logic          locked_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // One shared counter; it is cleared on every state entry so it never wraps.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    retry_nx = retry;
    if (restart) begin
      state_nx = RESET_HOLD;
      cnt_nx   = '0;
      retry_nx = '0;
    end else begin
      case (state)
        RESET_HOLD: if (cnt == CW'(RST_CYCLES - 1)) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end
        WAIT_LOCK: if (locked_s) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          retry_nx = retry + RW'(1);
          state_nx = (retry_nx == RW'(MAX_RETRY)) ? FAIL : RESET_HOLD;
          cnt_nx   = '0;
        end
        STABLE: if (!locked_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == CW'(LOCK_STABLE - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
          retry_nx = '0;
        end
        RUN: begin
          cnt_nx = '0;
          if (!locked_s) state_nx = RESET_HOLD;
        end
        FAIL: cnt_nx = '0;
        default: begin
          state_nx = RESET_HOLD;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_HOLD;
      cnt       <= '0;
      retry     <= '0;
      pll_rst   <= 1'b1;
      pll_ready <= 1'b0;
      pll_fail  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      retry     <= retry_nx;
      pll_rst   <= (state_nx == RESET_HOLD) || (state_nx == FAIL);
      pll_fail  <= (state_nx == FAIL);
      // Rises one cycle into RUN, drops on the edge that leaves RUN.
      pll_ready <= (state == RUN) && (state_nx == RUN);
    end
  end

  assign state_o = state;

`ifdef PLL_SEQ_LOL_COUNT_EN
  logic       lol_evt;
  logic [7:0] lol_q;

  // A restart coinciding with lock loss is not an LOL event.
  assign lol_evt = (state == RUN) && !locked_s && !restart;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)                          lol_q <= 8'd0;
    else if (lol_evt && lol_q != 8'hFF)  lol_q <= lol_q + 8'd1;
  end

  assign lol_count = lol_q;
`else
  assign lol_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=20,
// LOCK_STABLE=8, MAX_RETRY=2; table rows plus hand sequences for corners.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n, restart, pll_locked;
  logic       pll_rst, pll_ready, pll_fail;
  logic [2:0] state_o;
  logic [7:0] lol_count;

  int total = 0;
  int bad   = 0;

`ifdef PLL_SEQ_LOL_COUNT_EN
  localparam logic [7:0] LOL_EXP = 8'd1;
`else
  localparam logic [7:0] LOL_EXP = 8'd0;
`endif

  pll_reset_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_STABLE(8), .MAX_RETRY(2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .restart    (restart),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .pll_ready  (pll_ready),
    .pll_fail   (pll_fail),
    .state_o    (state_o),
    .lol_count  (lol_count)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic       restart;
    logic       locked;
    logic [5:0] exp;   // {state, pll_rst, pll_ready, pll_fail}
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] o(input logic [2:0] st, input logic r,
                                   input logic rd, input logic f);
    return {st, r, rd, f};
  endfunction

  task automatic add(input int n, input logic rs, input logic lk, input logic [5:0] e);
    vec_t v;
    v.restart = rs; v.locked = lk; v.exp = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {state_o, pll_rst, pll_ready, pll_fail};
  endfunction

  // Expected outputs t cycles after a restart with lock held low.
  function automatic logic [5:0] to_exp(input int t);
    if (t < 4)  return o(3'd0, 1, 0, 0);
    if (t < 24) return o(3'd1, 0, 0, 0);
    if (t < 28) return o(3'd0, 1, 0, 0);
    if (t < 48) return o(3'd1, 0, 0, 0);
    return o(3'd4, 1, 0, 1);
  endfunction

  // Lock chatter: locked on edges 5..9, low on 10, high from 11.
  function automatic logic [5:0] chat_exp(input int t);
    if (t < 4)   return o(3'd0, 1, 0, 0);
    if (t < 7)   return o(3'd1, 0, 0, 0);
    if (t < 12)  return o(3'd2, 0, 0, 0);
    if (t == 12) return o(3'd1, 0, 0, 0);
    if (t < 21)  return o(3'd2, 0, 0, 0);
    if (t == 21) return o(3'd3, 0, 0, 0);
    return o(3'd3, 0, 1, 0);
  endfunction

  initial begin
    rst_n = 1'b0; restart = 1'b0; pll_locked = 1'b0;

    // Bring-up, lock 5 cycles after pll_rst falls, then a loss of lock.
    add(3, 0, 0, o(3'd0, 1, 0, 0));
    add(5, 0, 0, o(3'd1, 0, 0, 0));
    add(2, 0, 1, o(3'd1, 0, 0, 0));
    add(8, 0, 1, o(3'd2, 0, 0, 0));
    add(1, 0, 1, o(3'd3, 0, 0, 0));
    add(3, 0, 1, o(3'd3, 0, 1, 0));
    add(2, 0, 0, o(3'd3, 0, 1, 0));
    add(4, 0, 0, o(3'd0, 1, 0, 0));
    add(1, 0, 0, o(3'd1, 0, 0, 0));

    #22;
    chk("reset", 0, {2'b00, outs()}, {2'b00, o(3'd0, 1, 0, 0)});
    chk("reset_lol", 0, lol_count, 8'd0);
    rst_n = 1'b1;
    #1;

    foreach (tbl[i]) begin
      restart    = tbl[i].restart;
      pll_locked = tbl[i].locked;
      step();
      chk("vec", i + 1, {2'b00, outs()}, {2'b00, tbl[i].exp});
    end
    chk("lol_count_after_lol", 0, lol_count, LOL_EXP);

    // Relock to RUN, then restart coinciding with a second loss of lock.
    pll_locked = 1'b1;
    for (int i = 0; i < 11; i++) step();
    chk("relock_run", 0, {2'b00, outs()}, {2'b00, o(3'd3, 0, 0, 0)});
    step();
    chk("relock_ready", 0, {2'b00, outs()}, {2'b00, o(3'd3, 0, 1, 0)});
    pll_locked = 1'b0;
    step();
    step();
    chk("drop_pending", 0, {2'b00, outs()}, {2'b00, o(3'd3, 0, 1, 0)});
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_on_lol", 0, {2'b00, outs()}, {2'b00, to_exp(0)});
    chk("lol_count_restart", 0, lol_count, LOL_EXP);

    // Two timeouts lead to FAIL, which then holds.
    for (int t = 1; t <= 52; t++) begin
      step();
      chk("timeout", t, {2'b00, outs()}, {2'b00, to_exp(t)});
    end

    // Restart out of FAIL must clear the retry count: two full retries again.
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("fail_restart", 0, {2'b00, outs()}, {2'b00, to_exp(0)});
    for (int t = 1; t <= 48; t++) begin
      step();
      chk("retry_cleared", t, {2'b00, outs()}, {2'b00, to_exp(t)});
    end

    // Lock chatter in STABLE.
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("chatter", 0, {2'b00, outs()}, {2'b00, chat_exp(0)});
    for (int t = 1; t <= 22; t++) begin
      pll_locked = ((t >= 5) && (t <= 9)) || (t >= 11);
      step();
      chk("chatter", t, {2'b00, outs()}, {2'b00, chat_exp(t)});
    end

    // Async reset while in WAIT_LOCK.
    pll_locked = 1'b0;
    restart    = 1'b1;
    step();
    restart = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("pre_async", 0, {2'b00, outs()}, {2'b00, o(3'd1, 0, 0, 0)});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 0, {2'b00, outs()}, {2'b00, o(3'd0, 1, 0, 0)});
    chk("async_lol", 0, lol_count, 8'd0);
    #4;
    rst_n = 1'b1;
    step();
    chk("post_async", 0, {2'b00, outs()}, {2'b00, o(3'd0, 1, 0, 0)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the reset and lock of the baremetal PLL (50 MHz refclk in, 100 MHz out).
- Drives the PLL reset and synchronizes/qualifies its asynchronous locked output.
- Asserts pll_ready only after lock has been stable for a set time.
- Recovers automatically from lock timeouts and loss-of-lock (LOL); parks in a fail state after repeated timeouts.
- Runs entirely in the refclk domain and sits between the board reset and the PLL/system reset tree.

Parameters:
- RST_CYCLES, 16: refclk cycles that pll_rst is held high in each reset pulse (min 1).
- LOCK_TIMEOUT, 50000: refclk cycles allowed in WAIT_LOCK before a timeout (1 ms at 50 MHz).
- LOCK_STABLE, 1024: consecutive cycles synchronized lock must stay high before pll_ready.
- MAX_RETRY, 3: number of consecutive timeouts that sends the block to FAIL (min 1).

Ports:
- refclk  in  1  reference clock; all logic is in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous single-cycle request to re-run the whole sequence.
- pll_locked  in  1  PLL locked output, asynchronous to refclk.
- pll_rst  out  1  PLL reset, active high.
- pll_ready  out  1  high only in RUN; qualified lock.
- pll_fail  out  1  high only in FAIL.
- state_o  out  3  current state encoding, for debug.
- lol_count  out  8  loss-of-lock event counter (see Optional Feature).

Behaviour:
- Reset values (rst_n low): pll_rst=1, pll_ready=0, pll_fail=0, state=RESET_HOLD, all counters=0, lock synchronizer=0, lol_count=0.
- Lock synchronizer: 2-flop on pll_locked giving locked_s, 2 cycles of latency. Only locked_s is used internally.
- State encoding: RESET_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- RESET_HOLD:
  - pll_rst=1; count from 0 to RST_CYCLES-1.
  - On the last count go to WAIT_LOCK; pll_rst falls on that edge.
  - Exactly RST_CYCLES cycles high, counted from the first refclk edge after rst_n releases.
- WAIT_LOCK:
  - pll_rst=0; timeout counter runs.
  - locked_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT-1 with locked_s=0: retry_cnt+1. Go to FAIL if the new value equals MAX_RETRY, otherwise to RESET_HOLD.
- STABLE:
  - Stability counter counts cycles with locked_s=1.
  - locked_s drops: go back to WAIT_LOCK with the timeout counter cleared (lock chatter, not LOL; retry_cnt unchanged).
  - LOCK_STABLE consecutive high cycles: go to RUN; retry_cnt cleared.
- RUN:
  - pll_ready=1, registered; rises 1 cycle after entering RUN.
  - locked_s=0: LOL event. pll_ready drops on the same edge as the state change; go to RESET_HOLD.
- FAIL: pll_rst=1, pll_fail=1; leaves only via restart or rst_n.
- restart=1 in any state:
  - Next state is RESET_HOLD; retry_cnt and all counters cleared.
  - Has priority over every other transition.
  - restart in the same cycle as an LOL in RUN is counted as a restart, not as an LOL.
- Counter widths: $clog2 of the max parameter, plus 1. No wrap: every counter clears on each state entry.
- Async reset mid-sequence: all state returns to reset values immediately; pll_rst is forced high asynchronously.

Optional Feature:
- Macro: PLL_SEQ_LOL_COUNT_EN.
- Defined: lol_count increments by 1 on each LOL event in RUN and saturates at 255. Cleared only by rst_n; not by restart.
- Undefined: lol_count is tied to 8'd0 and no counter register is built.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum typedef (3-bit), shared with the debug/CSR decode;
  - localparam defaults RST_CYCLES_DEF, LOCK_TIMEOUT_DEF, LOCK_STABLE_DEF, MAX_RETRY_DEF.
- One sub-module: sync_2ff, a generic 2-flop synchronizer with async active-low reset and reset value 0. It is used for pll_locked and is reusable elsewhere.
- The FSM and counters stay in the top module.

Test Plan (all scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2):
- Normal bring-up:
  - Stimulus: release rst_n; raise pll_locked 5 cycles after pll_rst falls.
  - Response: pll_rst high exactly 4 cycles; pll_ready rises 2 (sync) + 8 (stable) + 1 cycles after pll_locked rises; pll_fail stays 0.
- Timeout retry then fail:
  - Stimulus: hold pll_locked=0.
  - Response: two reset pulses of 4 cycles, each followed by 20 WAIT_LOCK cycles; then state_o=4, pll_fail=1, pll_rst=1 held.
  - Follow-on: pulse restart; the sequence restarts from RESET_HOLD with retry_cnt=0.
- Lock chatter in STABLE:
  - Stimulus: locked high 5 cycles, low 1 cycle, then high.
  - Response: state returns to WAIT_LOCK; pll_ready only after 8 uninterrupted high cycles; no reset pulse issued.
- Loss of lock in RUN:
  - Stimulus: from RUN, drop pll_locked.
  - Response: 2 cycles later pll_ready=0 and pll_rst=1 for 4 cycles; with the macro defined lol_count=1, without it 0.
  - Follow-on: restart asserted in the same cycle as a second drop leaves lol_count unchanged.
- Async reset mid-WAIT_LOCK:
  - Stimulus: assert rst_n low between edges.
  - Response: pll_rst goes high immediately without a clock edge; all outputs return to reset values; state_o=0.
